raket_ctrl: RTL and testbench
=============================

// Module: raket_ctrl
// PURPOSE
//   Motion controller for one pong paddle (raket). Conditions the raw push-button
//   inputs, decides the direction, and moves the paddle once per video frame.
//   Speed ramps up while a key is held, and the position is clamped to the visible
//   VGA area. Outputs left/right edge coordinates to the pixel renderer.
//   Sits between the board keys and the VGA drawing logic.
//   frame_tick comes from the VGA sync generator as a 1-cycle pulse per frame.
// PARAMETERS
//   H_MIN       144  first visible pixel column; left edge never goes below it
//   H_MAX       784  last visible column bound; right edge never exceeds it
//   PAD_W       100  paddle width; right = left + PAD_W at all times
//   INIT_LEFT   400  left edge after reset or center
//   STEP_SLOW   4    pixels per frame before the ramp-up completes
//   STEP_FAST   10   pixels per frame after the ramp-up
//   RAMP_FRAMES 8    number of consecutive same-direction moves before fast speed
//   DB_CYCLES   16   clk cycles a key must stay stable before it is accepted
// PORTS
//   clk         in   1   system clock (pixel clock domain)
//   rst_n       in   1   asynchronous active-low reset
//   key1        in   1   raw button, move left (async, may bounce)
//   key2        in   1   raw button, move right (async, may bounce)
//   frame_tick  in   1   1-cycle pulse per frame, synchronous to clk
//   center      in   1   synchronous request to return paddle to INIT_LEFT
//   left        out  16  paddle left-edge column
//   right       out  16  paddle right-edge column
//   at_wall_l   out  1   high when left == H_MIN
//   at_wall_r   out  1   high when right == H_MAX
//   moving      out  1   high when the FSM is in MOVE_L or MOVE_R
// BEHAVIOUR
// - Clock and reset
//   - One clock: clk.
//   - rst_n is asynchronous and active-low.
//   - Reset values: left=INIT_LEFT, right=INIT_LEFT+PAD_W, at_wall_l=0,
//     at_wall_r=0, moving=0, state=IDLE, ramp count=0.
//   - Synchronizer and debounce registers reset to 0.
// - Key conditioning
//   - Each key passes through a 2-flop synchronizer.
//   - A per-key debounce counter follows. The accepted level changes only after
//     the synchronized input has differed from it for DB_CYCLES consecutive clks.
//   - Any glitch restarts the counter.
// - Direction decode (debounced keys)
//   - Only key1 -> L. Only key2 -> R.
//   - Neither key, or both keys -> NONE (simultaneous press cancels).
// - FSM: IDLE, MOVE_L, MOVE_R
//   - State is evaluated only on cycles where frame_tick=1.
//   - dir=NONE -> IDLE, count=0, no move.
//   - dir=L/R, same direction as the current state -> move by step, then
//     count = min(count+1, RAMP_FRAMES).
//   - dir=L/R, from IDLE or the opposite direction -> count=0, move STEP_SLOW,
//     then count=1.
//   - step = STEP_FAST if count >= RAMP_FRAMES, otherwise STEP_SLOW. count is
//     taken before the increment.
// - Arithmetic
//   - Use 17-bit intermediates so that no wrap-around is possible.
//   - MOVE_L: left_n = max(H_MIN, left - step).
//   - MOVE_R: left_n = min(H_MAX - PAD_W, left + step).
//   - right is always left + PAD_W; the two are never updated independently.
// - Latency
//   - left, right and the wall flags take their new value at the clk edge that
//     samples frame_tick=1. They are all registered outputs.
//   - Key-to-motion delay: 2 sync clks + DB_CYCLES + wait for the next frame_tick.
// - Walls
//   - If the paddle is at a wall and still pushed into it, the position holds and
//     the state stays MOVE_x.
//   - The ramp count keeps saturating.
//   - A reversal leaves the wall at STEP_SLOW.
// - Center
//   - Takes priority over everything, frame_tick not required.
//   - Next clk: left=INIT_LEFT, state=IDLE, count=0.
// - Reset mid-operation
//   - Asserting rst_n low at any point immediately forces the reset values.
//   - After release, no movement happens until the keys have re-debounced.
// - frame_tick with no key held has no effect other than IDLE/count=0.
// TESTING
//   1 Reset, keys idle, 5 ticks -> left=400, right=500, flags 0, moving=0.
//   2 Hold key2, 10 ticks -> steps 4x8 then 10x2.
//     Result: left=452, right=552, moving=1.
//   3 Hold key2 until the wall -> left=684, right=784, at_wall_r=1.
//     Further ticks: no change. Then key1 for 1 tick -> left=680, at_wall_r=0.
//   4 Hold key1 from reset -> left reaches 144 and never goes below it;
//     at_wall_l=1; right=244.
//   5 Both keys held 3 ticks -> left unchanged, moving=0, count=0.
//   6 key2 bounce: toggle every 5 clks for 100 clks, ticks in between -> no
//     movement. Then center mid-ramp -> left=400 next clk.
//     Then rst_n pulse mid-move -> reset values immediately.

Source files
------------

// File: rtl/raket_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : raket_ctrl                                                       |
// | Brief   : pong paddle motion controller: key conditioning, ramped per-     |
// |           frame movement and clamping to the visible VGA columns.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module raket_ctrl #(
  parameter int H_MIN       = 144,
  parameter int H_MAX       = 784,
  parameter int PAD_W       = 100,
  parameter int INIT_LEFT   = 400,
  parameter int STEP_SLOW   = 4,
  parameter int STEP_FAST   = 10,
  parameter int RAMP_FRAMES = 8,
  parameter int DB_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key1,
  input  logic        key2,
  input  logic        frame_tick,
  input  logic        center,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        at_wall_l,
  output logic        at_wall_r,
  output logic        moving
);

  localparam int c_DB_W   = $clog2(DB_CYCLES + 1);
  localparam int c_RAMP_W = $clog2(RAMP_FRAMES + 1);

  localparam logic [15:0] c_H_MIN     = 16'(H_MIN);
  localparam logic [15:0] c_H_MAX     = 16'(H_MAX);
  localparam logic [15:0] c_PAD_W     = 16'(PAD_W);
  localparam logic [15:0] c_LEFT_MAX  = 16'(H_MAX - PAD_W);
  localparam logic [15:0] c_INIT_L    = 16'(INIT_LEFT);
  localparam logic [15:0] c_INIT_R    = 16'(INIT_LEFT + PAD_W);
  localparam logic [15:0] c_STEP_SLOW = 16'(STEP_SLOW);
  localparam logic [15:0] c_STEP_FAST = 16'(STEP_FAST);
  localparam logic [c_RAMP_W-1:0] c_RAMP = c_RAMP_W'(RAMP_FRAMES);
  localparam logic [c_DB_W-1:0]   c_DB_LAST = c_DB_W'(DB_CYCLES - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_MOVE_L = 2'd1;
  localparam logic [1:0] c_MOVE_R = 2'd2;

  logic [1:0] w_key_raw;
  logic [1:0] w_key_db;

  assign w_key_raw = {key2, key1};

  for (genvar i = 0; i < 2; i++) begin : g_key
    logic              r_meta;
    logic              r_sync;
    logic              r_db;
    logic [c_DB_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
        r_db   <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_meta <= w_key_raw[i];
        r_sync <= r_meta;
        // Any sample matching the accepted level restarts the stability window.
        if (r_sync == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_db  <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_key_db[i] = r_db;
  end

  logic                w_dir_l;
  logic                w_dir_r;
  logic [1:0]          r_state;
  logic [1:0]          w_state_n;
  logic [c_RAMP_W-1:0] r_ramp;
  logic [c_RAMP_W-1:0] w_ramp_n;
  logic [15:0]         r_left;
  logic [15:0]         r_right;
  logic                r_wall_l;
  logic                r_wall_r;
  logic [15:0]         w_left_n;
  logic [15:0]         w_step;
  logic                w_same;

  assign w_dir_l = w_key_db[0] & ~w_key_db[1];
  assign w_dir_r = w_key_db[1] & ~w_key_db[0];
  assign w_same  = (w_dir_l && r_state == c_MOVE_L) || (w_dir_r && r_state == c_MOVE_R);

  always_comb begin
    w_state_n = r_state;
    w_ramp_n  = r_ramp;
    w_left_n  = r_left;
    w_step    = c_STEP_SLOW;
    if (center) begin
      w_state_n = c_IDLE;
      w_ramp_n  = '0;
      w_left_n  = c_INIT_L;
    end else if (frame_tick) begin
      if (!w_dir_l && !w_dir_r) begin
        w_state_n = c_IDLE;
        w_ramp_n  = '0;
      end else begin
        if (w_same) begin
          w_step   = (r_ramp >= c_RAMP) ? c_STEP_FAST : c_STEP_SLOW;
          w_ramp_n = (r_ramp >= c_RAMP) ? c_RAMP : r_ramp + 1'b1;
        end else begin
          w_state_n = w_dir_l ? c_MOVE_L : c_MOVE_R;
          w_ramp_n  = c_RAMP_W'(1);
        end
        // 17-bit decisions so neither the subtraction nor the addition can wrap.
        if (w_dir_l) begin
          if ({1'b0, r_left} < ({1'b0, c_H_MIN} + {1'b0, w_step}))
            w_left_n = c_H_MIN;
          else
            w_left_n = r_left - w_step;
        end else begin
          if (({1'b0, r_left} + {1'b0, w_step}) > {1'b0, c_LEFT_MAX})
            w_left_n = c_LEFT_MAX;
          else
            w_left_n = r_left + w_step;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_ramp   <= '0;
      r_left   <= c_INIT_L;
      r_right  <= c_INIT_R;
      r_wall_l <= 1'b0;
      r_wall_r <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_ramp   <= w_ramp_n;
      r_left   <= w_left_n;
      r_right  <= w_left_n + c_PAD_W;
      r_wall_l <= (w_left_n == c_H_MIN);
      r_wall_r <= ((w_left_n + c_PAD_W) == c_H_MAX);
    end
  end

  assign left      = r_left;
  assign right     = r_right;
  assign at_wall_l = r_wall_l;
  assign at_wall_r = r_wall_r;
  assign moving    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_raket_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_raket_ctrl                                                    |
// | Brief   : scoreboard bench for raket_ctrl with a frame-level paddle model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_raket_ctrl;

  localparam int H_MIN = 144, H_MAX = 784, PAD_W = 100, INIT_LEFT = 400;
  localparam int STEP_SLOW = 4, STEP_FAST = 10, RAMP_FRAMES = 8;
  localparam int SETTLE = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key1 = 1'b0, key2 = 1'b0, frame_tick = 1'b0, center = 1'b0;
  logic [15:0] left, right;
  logic        at_wall_l, at_wall_r, moving;

  always #5 clk = ~clk;

  raket_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key1(key1), .key2(key2),
    .frame_tick(frame_tick), .center(center),
    .left(left), .right(right), .at_wall_l(at_wall_l),
    .at_wall_r(at_wall_r), .moving(moving)
  );

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        wl;
    logic        wr;
    logic        mv;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: paddle position, ramp count, direction (0 idle, 1 left, 2 right)
  int m_left = INIT_LEFT, m_cnt = 0, m_dir = 0;
  bit m_k1 = 1'b0, m_k2 = 1'b0;

  function automatic exp_t m_out();
    exp_t e;
    e.l  = 16'(m_left);
    e.r  = 16'(m_left + PAD_W);
    e.wl = (m_left == H_MIN);
    e.wr = (m_left + PAD_W == H_MAX);
    e.mv = (m_dir != 0);
    return e;
  endfunction

  function automatic void m_frame();
    int d, step;
    d = (m_k1 && !m_k2) ? 1 : ((m_k2 && !m_k1) ? 2 : 0);
    if (d == 0) begin
      m_dir = 0;
      m_cnt = 0;
      return;
    end
    if (d == m_dir) begin
      step  = (m_cnt >= RAMP_FRAMES) ? STEP_FAST : STEP_SLOW;
      m_cnt = (m_cnt + 1 > RAMP_FRAMES) ? RAMP_FRAMES : m_cnt + 1;
    end else begin
      step  = STEP_SLOW;
      m_cnt = 1;
      m_dir = d;
    end
    if (d == 1) m_left = (m_left - step < H_MIN) ? H_MIN : m_left - step;
    else        m_left = (m_left + step > H_MAX - PAD_W) ? H_MAX - PAD_W : m_left + step;
  endfunction

  function automatic void m_home();
    m_left = INIT_LEFT;
    m_cnt  = 0;
    m_dir  = 0;
  endfunction

  task automatic compare(input string nm, input exp_t e);
    n_tests++;
    if ({left, right, at_wall_l, at_wall_r, moving} !== e) begin
      n_fail++;
      $display("FAIL %s: got left=%0d right=%0d wl=%0b wr=%0b mv=%0b, want left=%0d right=%0d wl=%0b wr=%0b mv=%0b",
               nm, left, right, at_wall_l, at_wall_r, moving, e.l, e.r, e.wl, e.wr, e.mv);
    end
  endtask

  function automatic exp_t mk(input int l, input bit wl, input bit wr, input bit mv);
    exp_t e;
    e.l = 16'(l); e.r = 16'(l + PAD_W); e.wl = wl; e.wr = wr; e.mv = mv;
    return e;
  endfunction

  // Monitor: every cycle that samples frame_tick or center yields one output to check.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && (frame_tick || center)) begin
        @(negedge clk);
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard_empty: got left=%0d, want a queued expectation", left);
        end else begin
          compare(qn.pop_front(), q.pop_front());
        end
      end
    end
  end

  task automatic do_tick(input string nm);
    @(negedge clk);
    m_frame();
    q.push_back(m_out());
    qn.push_back(nm);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_center(input string nm);
    @(negedge clk);
    m_home();
    q.push_back(m_out());
    qn.push_back(nm);
    center = 1'b1;
    @(negedge clk);
    center = 1'b0;
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
    m_k1 = key1;
    m_k2 = key2;
  endtask

  task automatic set_keys(input bit a, input bit b);
    @(negedge clk);
    key1 = a;
    key2 = b;
    settle();
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_home();
    m_k1 = 1'b0;
    m_k2 = 1'b0;
    compare(nm, m_out());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    #23;
    compare("reset_state", mk(INIT_LEFT, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    repeat (5) do_tick("idle_tick");
    compare("idle_const", mk(400, 1'b0, 1'b0, 1'b0));

    set_keys(1'b0, 1'b1);
    repeat (10) do_tick("ramp_right");
    compare("ramp_452", mk(452, 1'b0, 1'b0, 1'b1));

    repeat (30) do_tick("to_wall_r");
    compare("wall_r", mk(684, 1'b0, 1'b1, 1'b1));
    repeat (3) do_tick("hold_wall_r");
    set_keys(1'b1, 1'b0);
    do_tick("leave_wall_r");
    compare("leave_wall_r_680", mk(680, 1'b0, 1'b0, 1'b1));

    do_reset("reset_key1_held");
    settle();
    repeat (45) do_tick("to_wall_l");
    compare("wall_l", mk(144, 1'b1, 1'b0, 1'b1));

    set_keys(1'b1, 1'b1);
    repeat (3) do_tick("both_keys");
    compare("both_cancel", mk(144, 1'b1, 1'b0, 1'b0));
    set_keys(1'b0, 1'b1);
    do_tick("after_cancel");
    compare("after_cancel_slow", mk(148, 1'b0, 1'b0, 1'b1));

    set_keys(1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c % 5 == 0) key2 = ~key2;
      if (c % 7 == 3) begin
        m_frame();
        q.push_back(m_out());
        qn.push_back("bounce_tick");
        frame_tick = 1'b1;
      end else begin
        frame_tick = 1'b0;
      end
    end
    @(negedge clk);
    frame_tick = 1'b0;
    compare("bounce_no_move", mk(148, 1'b0, 1'b0, 1'b0));

    set_keys(1'b0, 1'b1);
    repeat (5) do_tick("pre_center");
    do_center("center");
    compare("center_400", mk(400, 1'b0, 1'b0, 1'b0));
    repeat (3) do_tick("pre_reset");
    do_reset("reset_mid_move");
    do_tick("post_reset_no_move");
    settle();
    do_tick("post_settle");
    compare("post_settle_404", mk(404, 1'b0, 1'b0, 1'b1));

    for (int it = 0; it < 30; it++) begin
      int n;
      set_keys(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 14);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 9) == 0) do_center("rand_center");
        else                           do_tick("rand_tick");
      end
      if ($urandom_range(0, 14) == 0) begin
        do_reset("rand_reset");
        settle();
      end
    end

    repeat (5) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
